// File: rtl/axi4_slave_mem_if.sv
// AXI4 bus bundle between a master (BFM) and the axi4_slave_mem responder.
interface axi4_slave_mem_if;
  // Write address channel
  logic        S_AXI_AWID;
  logic [31:0] S_AXI_AWADDR;
  logic [7:0]  S_AXI_AWLEN;
  logic [2:0]  S_AXI_AWSIZE;
  logic [1:0]  S_AXI_AWBURST;
  logic        S_AXI_AWLOCK;
  logic [3:0]  S_AXI_AWCACHE;
  logic [2:0]  S_AXI_AWPROT;
  logic [3:0]  S_AXI_AWREGION;
  logic [3:0]  S_AXI_AWQOS;
  logic        S_AXI_AWUSER;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  // Write data channel
  logic        S_AXI_WID;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WLAST;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  // Write response channel
  logic        S_AXI_BID;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BUSER;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  // Read address channel
  logic        S_AXI_ARID;
  logic [31:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic [2:0]  S_AXI_ARSIZE;
  logic [1:0]  S_AXI_ARBURST;
  logic        S_AXI_ARLOCK;
  logic [3:0]  S_AXI_ARCACHE;
  logic [2:0]  S_AXI_ARPROT;
  logic [3:0]  S_AXI_ARREGION;
  logic [3:0]  S_AXI_ARQOS;
  logic        S_AXI_ARUSER;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  // Read data channel
  logic        S_AXI_RID;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RUSER;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
           S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWREGION, S_AXI_AWQOS, S_AXI_AWUSER,
           S_AXI_AWVALID,
           S_AXI_WID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
           S_AXI_BREADY,
           S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
           S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARREGION, S_AXI_ARQOS, S_AXI_ARUSER,
           S_AXI_ARVALID,
           S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
           S_AXI_BID, S_AXI_BRESP, S_AXI_BUSER, S_AXI_BVALID,
           S_AXI_ARREADY,
           S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RUSER, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
           S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWREGION, S_AXI_AWQOS, S_AXI_AWUSER,
           S_AXI_AWVALID,
           S_AXI_WID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
           S_AXI_BREADY,
           S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
           S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARREGION, S_AXI_ARQOS, S_AXI_ARUSER,
           S_AXI_ARVALID,
           S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
           S_AXI_BID, S_AXI_BRESP, S_AXI_BUSER, S_AXI_BVALID,
           S_AXI_ARREADY,
           S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RUSER, S_AXI_RVALID
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed RAM. Independent write and read FSMs,
// INCR/FIXED bursts, SLVERR for unsupported size/burst or misplaced WLAST.
module axi4_slave_mem #(
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned RD_WAIT = 0
) (
  input logic             ACLK,
  input logic             ARESETN,
  axi4_slave_mem_if.slave s_axi
);

  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam logic [3:0] RD_WAIT_CYC = 4'(RD_WAIT);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  function automatic logic unsupported(input logic [2:0] size, input logic [1:0] burst);
    return !(burst == 2'b00 || burst == 2'b01) || (size != 3'b010);
  endfunction

  logic [31:0] mem [DEPTH];

  // Keeps both address READYs low for the first cycle out of reset.
  logic ready_en_q;

  logic [1:0]        w_state_q;
  logic              w_id_q;
  logic [MEM_AW-1:0] w_idx_q;
  logic [7:0]        w_len_q;
  logic [7:0]        w_cnt_q;
  logic              w_fixed_q;
  logic              w_err_q;

  logic [1:0]        r_state_q;
  logic              r_id_q;
  logic [MEM_AW-1:0] r_idx_q;
  logic [MEM_AW-1:0] r_idx_nxt;
  logic [7:0]        r_len_q;
  logic [7:0]        r_cnt_q;
  logic              r_fixed_q;
  logic              r_err_q;
  logic [3:0]        r_wait_q;
  logic [31:0]       rdata_q;

  logic aw_hs, w_hs, w_last_beat;
  logic ar_hs, r_hs, r_last_beat;

  assign aw_hs       = s_axi.S_AXI_AWREADY & s_axi.S_AXI_AWVALID;
  assign w_hs        = s_axi.S_AXI_WREADY & s_axi.S_AXI_WVALID;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign ar_hs       = s_axi.S_AXI_ARREADY & s_axi.S_AXI_ARVALID;
  assign r_hs        = s_axi.S_AXI_RVALID & s_axi.S_AXI_RREADY;
  assign r_last_beat = (r_cnt_q == r_len_q);
  assign r_idx_nxt   = r_fixed_q ? r_idx_q : r_idx_q + 1'b1;

  assign s_axi.S_AXI_AWREADY = ready_en_q & (w_state_q == W_IDLE);
  assign s_axi.S_AXI_WREADY  = (w_state_q == W_DATA);
  assign s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
  assign s_axi.S_AXI_BID     = w_id_q;
  assign s_axi.S_AXI_BRESP   = {w_err_q, 1'b0};
  assign s_axi.S_AXI_BUSER   = 1'b0;

  assign s_axi.S_AXI_ARREADY = ready_en_q & (r_state_q == R_IDLE);
  assign s_axi.S_AXI_RVALID  = (r_state_q == R_DATA);
  assign s_axi.S_AXI_RID     = r_id_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = {r_err_q, 1'b0};
  assign s_axi.S_AXI_RLAST   = s_axi.S_AXI_RVALID & r_last_beat;
  assign s_axi.S_AXI_RUSER   = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi.S_AXI_AWADDR[31:MEM_AW+2], s_axi.S_AXI_AWADDR[1:0],
                           s_axi.S_AXI_ARADDR[31:MEM_AW+2], s_axi.S_AXI_ARADDR[1:0],
                           s_axi.S_AXI_WID, s_axi.S_AXI_AWLOCK, s_axi.S_AXI_AWCACHE,
                           s_axi.S_AXI_AWPROT, s_axi.S_AXI_AWREGION, s_axi.S_AXI_AWQOS,
                           s_axi.S_AXI_AWUSER, s_axi.S_AXI_ARLOCK, s_axi.S_AXI_ARCACHE,
                           s_axi.S_AXI_ARPROT, s_axi.S_AXI_ARREGION, s_axi.S_AXI_ARQOS,
                           s_axi.S_AXI_ARUSER};

  // Address-ready enable: set on the first edge after reset release.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) ready_en_q <= 1'b0;
    else          ready_en_q <= 1'b1;
  end

  // Write FSM: accept AW, consume len+1 beats, then hold the B response.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      w_id_q    <= 1'b0;
      w_idx_q   <= '0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            w_id_q    <= s_axi.S_AXI_AWID;
            w_idx_q   <= s_axi.S_AXI_AWADDR[MEM_AW+1:2];
            w_len_q   <= s_axi.S_AXI_AWLEN;
            w_cnt_q   <= 8'd0;
            w_fixed_q <= (s_axi.S_AXI_AWBURST == 2'b00);
            w_err_q   <= unsupported(s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST);
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            // The beat count, not WLAST, ends the burst; a mismatch only flags an error.
            if (s_axi.S_AXI_WLAST != w_last_beat) w_err_q <= 1'b1;
            if (!w_fixed_q) w_idx_q <= w_idx_q + 1'b1;
            if (w_last_beat) w_state_q <= W_RESP;
            else             w_cnt_q   <= w_cnt_q + 8'd1;
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // RAM write port: byte-enabled, suppressed for errored bursts.
  always_ff @(posedge ACLK) begin
    if (ARESETN && w_hs && !w_err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.S_AXI_WSTRB[b]) mem[w_idx_q][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Read FSM: accept AR, wait RD_WAIT cycles plus one RAM read, stream len+1 beats.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      r_id_q    <= 1'b0;
      r_idx_q   <= '0;
      r_len_q   <= 8'd0;
      r_cnt_q   <= 8'd0;
      r_fixed_q <= 1'b0;
      r_err_q   <= 1'b0;
      r_wait_q  <= 4'd0;
      rdata_q   <= 32'h0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            r_id_q    <= s_axi.S_AXI_ARID;
            r_idx_q   <= s_axi.S_AXI_ARADDR[MEM_AW+1:2];
            r_len_q   <= s_axi.S_AXI_ARLEN;
            r_cnt_q   <= 8'd0;
            r_fixed_q <= (s_axi.S_AXI_ARBURST == 2'b00);
            r_err_q   <= unsupported(s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARBURST);
            r_wait_q  <= RD_WAIT_CYC;
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_wait_q != 4'd0) begin
            r_wait_q <= r_wait_q - 4'd1;
          end else begin
            rdata_q   <= r_err_q ? 32'h0 : mem[r_idx_q];
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (r_last_beat) begin
              r_state_q <= R_IDLE;
            end else begin
              // Prefetch the next beat so RREADY held high gives one beat per cycle.
              r_cnt_q <= r_cnt_q + 8'd1;
              r_idx_q <= r_idx_nxt;
              rdata_q <= r_err_q ? 32'h0 : mem[r_idx_nxt];
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem (MEM_AW=4 so wrap/alias cases are reachable).
module tb_axi4_slave_mem;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;

  axi4_slave_mem_if s_axi();

  axi4_slave_mem #(
    .MEM_AW (4),
    .RD_WAIT(0)
  ) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .s_axi  (s_axi)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;

  logic [31:0] wbuf [0:7];
  logic [31:0] ebuf [0:7];
  logic [1:0]  bresp;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({s_axi.S_AXI_AWREADY, s_axi.S_AXI_WREADY, s_axi.S_AXI_BVALID, s_axi.S_AXI_BID,
                s_axi.S_AXI_BRESP, s_axi.S_AXI_ARREADY, s_axi.S_AXI_RVALID, s_axi.S_AXI_RID,
                s_axi.S_AXI_RDATA, s_axi.S_AXI_RRESP, s_axi.S_AXI_RLAST, s_axi.S_AXI_BUSER,
                s_axi.S_AXI_RUSER});
  endfunction

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] strb, input bit early_last,
                           input int bdly, input logic id, output logic [1:0] resp);
    int n;
    check("wready_before_aw", 64'(s_axi.S_AXI_WREADY), 64'd0);
    s_axi.S_AXI_AWID    = id;
    s_axi.S_AXI_AWADDR  = addr;
    s_axi.S_AXI_AWLEN   = 8'(len);
    s_axi.S_AXI_AWSIZE  = size;
    s_axi.S_AXI_AWBURST = burst;
    s_axi.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (s_axi.S_AXI_AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
    check("awready_wait", 64'(n < 50), 64'd1);
    tick();
    s_axi.S_AXI_AWVALID = 1'b0;
    check("wready_after_aw", 64'(s_axi.S_AXI_WREADY), 64'd1);
    check("awready_busy", 64'(s_axi.S_AXI_AWREADY), 64'd0);
    for (int i = 0; i <= len; i++) begin
      s_axi.S_AXI_WDATA  = wbuf[i];
      s_axi.S_AXI_WSTRB  = strb;
      s_axi.S_AXI_WLAST  = early_last ? (i == 0) : (i == len);
      s_axi.S_AXI_WVALID = 1'b1;
      n = 0;
      while (s_axi.S_AXI_WREADY !== 1'b1 && n < 50) begin tick(); n++; end
      if (n >= 50) check("wready_wait", 64'(n), 64'd0);
      tick();
    end
    s_axi.S_AXI_WVALID = 1'b0;
    s_axi.S_AXI_WLAST  = 1'b0;
    check("bvalid_rise", 64'(s_axi.S_AXI_BVALID), 64'd1);
    for (int i = 0; i < bdly; i++) begin
      tick();
      check("bvalid_hold", 64'(s_axi.S_AXI_BVALID), 64'd1);
    end
    check("bid", 64'(s_axi.S_AXI_BID), 64'(id));
    resp = s_axi.S_AXI_BRESP;
    s_axi.S_AXI_BREADY = 1'b1;
    tick();
    s_axi.S_AXI_BREADY = 1'b0;
    check("bvalid_drop", 64'(s_axi.S_AXI_BVALID), 64'd0);
    check("awready_back", 64'(s_axi.S_AXI_AWREADY), 64'd1);
  endtask

  // Checks every RVALID cycle (stalled or not) against ebuf[beat].
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id, input bit stall,
                          input logic [1:0] eresp);
    int n;
    int beat;
    s_axi.S_AXI_ARID    = id;
    s_axi.S_AXI_ARADDR  = addr;
    s_axi.S_AXI_ARLEN   = 8'(len);
    s_axi.S_AXI_ARSIZE  = size;
    s_axi.S_AXI_ARBURST = burst;
    s_axi.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (s_axi.S_AXI_ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
    check("arready_wait", 64'(n < 50), 64'd1);
    tick();
    s_axi.S_AXI_ARVALID = 1'b0;
    check("rvalid_early", 64'(s_axi.S_AXI_RVALID), 64'd0);
    tick();
    check("rvalid_first", 64'(s_axi.S_AXI_RVALID), 64'd1);
    beat = 0;
    n = 0;
    while (beat <= len && n < 300) begin
      s_axi.S_AXI_RREADY = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!stall) check("rvalid_stream", 64'(s_axi.S_AXI_RVALID), 64'd1);
      if (s_axi.S_AXI_RVALID === 1'b1) begin
        check("rdata", 64'(s_axi.S_AXI_RDATA), 64'(ebuf[beat]));
        check("rlast", 64'(s_axi.S_AXI_RLAST), 64'(beat == len));
        check("rresp", 64'(s_axi.S_AXI_RRESP), 64'(eresp));
        check("rid", 64'(s_axi.S_AXI_RID), 64'(id));
        if (s_axi.S_AXI_RREADY) beat++;
      end
      tick();
      n++;
    end
    s_axi.S_AXI_RREADY = 1'b0;
    check("read_beats", 64'(beat), 64'(len + 1));
    check("rvalid_end", 64'(s_axi.S_AXI_RVALID), 64'd0);
    check("arready_back", 64'(s_axi.S_AXI_ARREADY), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_axi.S_AXI_AWID = 1'b0;    s_axi.S_AXI_AWADDR = 32'h0;  s_axi.S_AXI_AWLEN = 8'h0;
    s_axi.S_AXI_AWSIZE = 3'd2;  s_axi.S_AXI_AWBURST = 2'b01; s_axi.S_AXI_AWLOCK = 1'b0;
    s_axi.S_AXI_AWCACHE = 4'h0; s_axi.S_AXI_AWPROT = 3'h0;   s_axi.S_AXI_AWREGION = 4'h0;
    s_axi.S_AXI_AWQOS = 4'h0;   s_axi.S_AXI_AWUSER = 1'b0;   s_axi.S_AXI_AWVALID = 1'b0;
    s_axi.S_AXI_WID = 1'b0;     s_axi.S_AXI_WDATA = 32'h0;   s_axi.S_AXI_WSTRB = 4'h0;
    s_axi.S_AXI_WLAST = 1'b0;   s_axi.S_AXI_WVALID = 1'b0;   s_axi.S_AXI_BREADY = 1'b0;
    s_axi.S_AXI_ARID = 1'b0;    s_axi.S_AXI_ARADDR = 32'h0;  s_axi.S_AXI_ARLEN = 8'h0;
    s_axi.S_AXI_ARSIZE = 3'd2;  s_axi.S_AXI_ARBURST = 2'b01; s_axi.S_AXI_ARLOCK = 1'b0;
    s_axi.S_AXI_ARCACHE = 4'h0; s_axi.S_AXI_ARPROT = 3'h0;   s_axi.S_AXI_ARREGION = 4'h0;
    s_axi.S_AXI_ARQOS = 4'h0;   s_axi.S_AXI_ARUSER = 1'b0;   s_axi.S_AXI_ARVALID = 1'b0;
    s_axi.S_AXI_RREADY = 1'b0;

    // Reset: all outputs low, READYs rise one edge after release.
    ARESETN = 1'b0;
    tick();
    tick();
    check("reset_outs", outs(), 64'h0);
    ARESETN = 1'b1;
    check("ready_before_edge", 64'(s_axi.S_AXI_AWREADY), 64'd0);
    tick();
    check("awready_post_reset", 64'(s_axi.S_AXI_AWREADY), 64'd1);
    check("arready_post_reset", 64'(s_axi.S_AXI_ARREADY), 64'd1);

    // Single write, BREADY delayed 3 cycles, then readback (word 4).
    wbuf[0] = 32'h12345678;
    axi_write(32'h10, 0, 3'd2, 2'b00, 4'hF, 1'b0, 3, 1'b1, bresp);
    check("single_bresp", 64'(bresp), 64'd0);
    ebuf[0] = 32'h12345678;
    axi_read(32'h10, 0, 3'd2, 2'b01, 1'b1, 1'b0, 2'b00);

    // INCR burst of 4 (words 0..3), read back with random RREADY stalls.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    axi_write(32'h100, 3, 3'd2, 2'b01, 4'hF, 1'b0, 0, 1'b0, bresp);
    check("incr_bresp", 64'(bresp), 64'd0);
    for (int i = 0; i < 4; i++) ebuf[i] = 32'hA0 + 32'(i);
    axi_read(32'h100, 3, 3'd2, 2'b01, 1'b0, 1'b1, 2'b00);

    // Partial strobe: bytes 0 and 2 cleared.
    wbuf[0] = 32'hFFFF_FFFF;
    axi_write(32'h20, 0, 3'd2, 2'b01, 4'hF, 1'b0, 0, 1'b0, bresp);
    wbuf[0] = 32'h0000_0000;
    axi_write(32'h20, 0, 3'd2, 2'b01, 4'b0101, 1'b0, 0, 1'b0, bresp);
    ebuf[0] = 32'hFF00_FF00;
    axi_read(32'h20, 0, 3'd2, 2'b01, 1'b0, 1'b0, 2'b00);

    // FIXED write burst leaves only the last beat; FIXED read repeats the word.
    wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
    axi_write(32'h30, 2, 3'd2, 2'b00, 4'hF, 1'b0, 0, 1'b1, bresp);
    check("fixed_bresp", 64'(bresp), 64'd0);
    ebuf[0] = 32'd3; ebuf[1] = 32'd3;
    axi_read(32'h30, 1, 3'd2, 2'b00, 1'b1, 1'b0, 2'b00);

    // Unsupported burst type: beats consumed, RAM untouched, SLVERR.
    wbuf[0] = 32'hDEAD_0000; wbuf[1] = 32'hDEAD_0001;
    axi_write(32'h10, 1, 3'd2, 2'b10, 4'hF, 1'b0, 0, 1'b0, bresp);
    check("badburst_bresp", 64'(bresp), 64'd2);
    ebuf[0] = 32'h12345678;
    axi_read(32'h10, 0, 3'd2, 2'b01, 1'b0, 1'b0, 2'b00);

    // Early WLAST on beat 0 of a 2-beat burst.
    wbuf[0] = 32'h5555_0000; wbuf[1] = 32'h5555_0001;
    axi_write(32'h24, 1, 3'd2, 2'b01, 4'hF, 1'b1, 0, 1'b0, bresp);
    check("early_wlast_bresp", 64'(bresp), 64'd2);

    // Unsupported read size: zero data with SLVERR.
    ebuf[0] = 32'h0;
    axi_read(32'h10, 0, 3'd1, 2'b01, 1'b0, 1'b0, 2'b10);

    // Index wrap at word 15 -> word 0, and address aliasing above the RAM size.
    wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
    axi_write(32'h3C, 1, 3'd2, 2'b01, 4'hF, 1'b0, 0, 1'b0, bresp);
    check("wrap_bresp", 64'(bresp), 64'd0);
    ebuf[0] = 32'h2222_2222;
    axi_read(32'h00, 0, 3'd2, 2'b01, 1'b0, 1'b0, 2'b00);
    ebuf[0] = 32'h1111_1111; ebuf[1] = 32'h2222_2222;
    axi_read(32'h3C, 1, 3'd2, 2'b01, 1'b0, 1'b0, 2'b00);
    ebuf[0] = 32'h2222_2222;
    axi_read(32'h40, 0, 3'd2, 2'b01, 1'b0, 1'b0, 2'b00);

    // Reset during beat 2 of an 8-beat read.
    s_axi.S_AXI_ARID    = 1'b1;
    s_axi.S_AXI_ARADDR  = 32'h0;
    s_axi.S_AXI_ARLEN   = 8'd7;
    s_axi.S_AXI_ARSIZE  = 3'd2;
    s_axi.S_AXI_ARBURST = 2'b01;
    s_axi.S_AXI_ARVALID = 1'b1;
    check("arready_idle", 64'(s_axi.S_AXI_ARREADY), 64'd1);
    tick();
    s_axi.S_AXI_ARVALID = 1'b0;
    tick();
    s_axi.S_AXI_RREADY = 1'b1;
    tick();
    tick();
    check("beat2_valid", 64'(s_axi.S_AXI_RVALID), 64'd1);
    check("beat2_data", 64'(s_axi.S_AXI_RDATA), 64'hA2);
    check("beat2_nolast", 64'(s_axi.S_AXI_RLAST), 64'd0);
    ARESETN = 1'b0;
    tick();
    s_axi.S_AXI_RREADY = 1'b0;
    check("midburst_reset_outs", outs(), 64'h0);
    ARESETN = 1'b1;
    tick();
    check("arready_after_release", 64'(s_axi.S_AXI_ARREADY), 64'd1);
    check("rvalid_after_release", 64'(s_axi.S_AXI_RVALID), 64'd0);

    // RAM survives reset.
    ebuf[0] = 32'h12345678;
    axi_read(32'h10, 0, 3'd2, 2'b01, 1'b0, 1'b0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
